layer_out_serializer: RTL

- Sits directly downstream of one layer's neuron array, between that layer and the next.
- Captures all numNeurons activation outputs of the layer in one cycle.
- Streams them one per cycle, neuron 0 first, onto the next layer's shared myinput/myinputValid bus.
- Flags frame-alignment and overrun faults with sticky error bits.

---
 rtl/fnn_pkg.sv | 17 +
 rtl/layer_out_serializer.sv | 118 +++++++++++
 2 files changed

// File: rtl/fnn_pkg.sv
// Shared types and helpers for the feed-forward network datapath blocks.
// Holds the serializer state encoding and packed-bus slice indexing.
package fnn_pkg;

    localparam int DATA_WIDTH = 16;

    typedef enum logic {
        IDLE,
        SHIFT
    } ser_state_t;

    // LSB position of element idx on a bus of width-bit elements packed from bit 0 upward.
    function automatic int slice_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/layer_out_serializer.sv
// Captures one layer's parallel activations and streams them one per cycle,
// neuron 0 first, onto the next layer's shared input bus.
module layer_out_serializer
    import fnn_pkg::*;
#(
    parameter int numNeurons = 10,
    parameter int dataWidth  = DATA_WIDTH,
    parameter int cntWidth   = $clog2(numNeurons)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [numNeurons*dataWidth-1:0] in_data,
    input  logic [numNeurons-1:0]           in_valid,
    input  logic                            err_clear,
    output logic [dataWidth-1:0]            out_data,
    output logic                            out_valid,
    output logic                            busy,
    output logic                            frame_done,
    output logic                            err_mismatch,
    output logic                            err_overrun
);

    localparam logic [cntWidth-1:0] LAST = cntWidth'(numNeurons - 1);

    ser_state_t                      state_q, state_d;
    logic [cntWidth-1:0]             cnt_q, cnt_d;
    logic [numNeurons*dataWidth-1:0] shbuf_q, shbuf_d;
    logic [dataWidth-1:0]            out_data_q, out_data_d;
    logic                            out_valid_q, out_valid_d;
    logic                            frame_done_q, frame_done_d;
    logic                            mis_q, mis_d;
    logic                            ovr_q, ovr_d;

    logic                            accept;
    logic [cntWidth-1:0]             nxt_idx;

    // A new frame may only enter when idle or on the edge retiring the last beat.
    assign accept  = in_valid[0] && ((state_q == IDLE) || (cnt_q == LAST));
    assign nxt_idx = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shbuf_d      = shbuf_q;
        out_data_d   = out_data_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        mis_d        = mis_q & ~err_clear;
        ovr_d        = ovr_q & ~err_clear;

        if (accept) begin
            shbuf_d     = in_data;
            cnt_d       = '0;
            state_d     = SHIFT;
            out_data_d  = in_data[slice_lsb(0, dataWidth) +: dataWidth];
            out_valid_d = 1'b1;
            if (in_valid != {numNeurons{1'b1}}) begin
                mis_d = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                SHIFT: begin
                    if (cnt_q == LAST) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d        = nxt_idx;
                        out_data_d   = shbuf_q[slice_lsb(int'(nxt_idx), dataWidth) +: dataWidth];
                        out_valid_d  = 1'b1;
                        frame_done_d = (nxt_idx == LAST);
                        // Mid-frame trigger is dropped; the current frame keeps going.
                        if (in_valid[0]) begin
                            ovr_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            mis_q        <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            mis_q        <= mis_d;
            ovr_q        <= ovr_d;
        end
    end

    // The shift buffer carries no reset; its contents only matter once a capture loads it.
    always_ff @(posedge clk) begin
        shbuf_q <= shbuf_d;
    end

    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;
    assign busy         = (state_q == SHIFT);
    assign frame_done   = frame_done_q;
    assign err_mismatch = mis_q;
    assign err_overrun  = ovr_q;

endmodule
